// File: rtl/aes_ks_pkg.sv
// rtl/aes_ks_pkg.sv - shared encodings for the AES key-schedule controller
// Contents: key-length codes, round-key counts per length, controller FSM states,
//           and a helper mapping a length code to its round-key count.
package aes_ks_pkg;

    localparam logic [1:0] LEN_128 = 2'b00;
    localparam logic [1:0] LEN_192 = 2'b01;
    localparam logic [1:0] LEN_256 = 2'b10;

    localparam logic [3:0] RK_N128 = 4'd11;
    localparam logic [3:0] RK_N192 = 4'd13;
    localparam logic [3:0] RK_N256 = 4'd15;

    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KICK    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } ks_state_t;

    // Zero marks the illegal length code, so callers can use it as the legality test.
    function automatic logic [3:0] rk_count(input logic [1:0] len);
        case (len)
            LEN_128: return RK_N128;
            LEN_192: return RK_N192;
            LEN_256: return RK_N256;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_rk_store.sv
// rtl/aes_rk_store.sv - round-key register file, one write port, one registered read port
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  write port, written on posedge when we=1
//   re/raddr        read request; rdata updates one cycle later, holds otherwise
//   rdata           registered read data (0 for out-of-range addresses)
module aes_rk_store
    import aes_ks_pkg::*;
#(
    parameter int DEPTH = 15,
    parameter int W     = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [RK_IDX_W-1:0] waddr,
    input  logic [W-1:0]        wdata,
    input  logic                re,
    input  logic [RK_IDX_W-1:0] raddr,
    output logic [W-1:0]        rdata
);

    localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; consumers gate them with a valid flag.
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST)) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (raddr <= LAST) ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - sequences AES key expansion and serves round keys by index
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   key_req_valid/key_req_ready        key-load handshake (ready only in IDLE)
//   key_in, key_len_in                 left-justified key, length code (11 = illegal)
//   exp_key_flag, exp_key, exp_leng_key  load pulse and held key/length to the expander
//   exp_wo_0..exp_wo_3                 expander output words, wo_0 is the MSW
//   rk_valid, rk_num                   complete schedule present, number of round keys
//   rk_rd_en, rk_rd_idx                read request and index
//   rk_rd_data, rk_rd_vld              read data (0 if invalid/out of range), valid 1 cycle later
//   busy, err_len                      expansion in progress, illegal-length pulse
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
#(
    parameter int RK_DEPTH = 15,
    parameter int RK_W     = 128,
    parameter int KEY_W    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_req_valid,
    output logic                key_req_ready,
    input  logic [KEY_W-1:0]    key_in,
    input  logic [1:0]          key_len_in,
    output logic                exp_key_flag,
    output logic [KEY_W-1:0]    exp_key,
    output logic [1:0]          exp_leng_key,
    input  logic [31:0]         exp_wo_0,
    input  logic [31:0]         exp_wo_1,
    input  logic [31:0]         exp_wo_2,
    input  logic [31:0]         exp_wo_3,
    output logic                rk_valid,
    output logic [3:0]          rk_num,
    input  logic                rk_rd_en,
    input  logic [RK_IDX_W-1:0] rk_rd_idx,
    output logic [RK_W-1:0]     rk_rd_data,
    output logic                rk_rd_vld,
    output logic                busy,
    output logic                err_len
);

    ks_state_t           state;
    ks_state_t           state_nxt;
    logic                accept;
    logic                len_ok;
    logic [3:0]          n_q;
    logic [RK_IDX_W-1:0] cnt;
    logic                rd_gate;
    logic [RK_W-1:0]     store_rdata;

    assign len_ok        = (rk_count(key_len_in) != 4'd0);
    assign key_req_ready = (state == ST_IDLE);
    assign exp_key_flag  = (state == ST_KICK);
    assign busy          = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = key_req_valid;
                if (key_req_valid && len_ok) begin
                    state_nxt = ST_KICK;
                end
            end
            ST_KICK:    state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (cnt == n_q - 4'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            exp_key      <= '0;
            exp_leng_key <= '0;
            n_q          <= '0;
            cnt          <= '0;
            rk_valid     <= 1'b0;
            rk_num       <= '0;
            err_len      <= 1'b0;
            rk_rd_vld    <= 1'b0;
            rd_gate      <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_len <= 1'b0;
            // Key and length are captured on every accept; the expander only acts
            // on them after the KICK pulse, and an illegal request never kicks.
            if (accept) begin
                exp_key      <= key_in;
                exp_leng_key <= key_len_in;
                if (len_ok) begin
                    rk_valid <= 1'b0;
                    n_q      <= rk_count(key_len_in);
                end else begin
                    err_len  <= 1'b1;
                end
            end
            if (state == ST_KICK) begin
                cnt <= '0;
            end
            if (state == ST_COLLECT) begin
                cnt <= cnt + 4'd1;
            end
            if (state == ST_DONE) begin
                rk_valid <= 1'b1;
                rk_num   <= n_q;
            end
            // Validity is decided with the rk_valid seen in the request cycle, so a
            // read in the accept cycle still returns the previous schedule.
            rk_rd_vld <= rk_rd_en;
            if (rk_rd_en) begin
                rd_gate <= rk_valid && (rk_rd_idx < rk_num);
            end
        end
    end

    aes_rk_store #(
        .DEPTH (RK_DEPTH),
        .W     (RK_W)
    ) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (state == ST_COLLECT),
        .waddr (cnt),
        .wdata ({exp_wo_0, exp_wo_1, exp_wo_2, exp_wo_3}),
        .re    (rk_rd_en),
        .raddr (rk_rd_idx),
        .rdata (store_rdata)
    );

    assign rk_rd_data = rd_gate ? store_rdata : '0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    typedef logic [14:0][127:0] sched_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_req_valid;
    logic         key_req_ready;
    logic [255:0] key_in;
    logic [1:0]   key_len_in;
    logic         exp_key_flag;
    logic [255:0] exp_key;
    logic [1:0]   exp_leng_key;
    logic [31:0]  exp_wo_0, exp_wo_1, exp_wo_2, exp_wo_3;
    logic         rk_valid;
    logic [3:0]   rk_num;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_vld;
    logic         busy;
    logic         err_len;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .key_req_valid(key_req_valid), .key_req_ready(key_req_ready),
        .key_in(key_in), .key_len_in(key_len_in),
        .exp_key_flag(exp_key_flag), .exp_key(exp_key), .exp_leng_key(exp_leng_key),
        .exp_wo_0(exp_wo_0), .exp_wo_1(exp_wo_1), .exp_wo_2(exp_wo_2), .exp_wo_3(exp_wo_3),
        .rk_valid(rk_valid), .rk_num(rk_num),
        .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
        .rk_rd_data(rk_rd_data), .rk_rd_vld(rk_rd_vld),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    int n_vec = 0;
    int n_err = 0;
    int c = 0;

    // Model state: cycle numbers at which each observable event is due.
    bit           m_known = 0;
    int           free_at = 0, kick_at = -10, done_at = -10, err_at = -10;
    int           valid_on_at = -10, rd_at = -10;
    logic         m_valid = 0;
    logic [3:0]   m_num = 0;
    logic [255:0] m_exp_key = 0;
    logic [1:0]   m_len = 0;
    sched_t       m_sched = '0, pend_sched = '0, e_sched = '0;
    int           pend_num = 0, e_n = 0, e_idx = 0;
    logic [127:0] rd_exp = 0, last_rd = 0;

    // ---------------- AES key expansion from first principles ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x = 8'h01;
        for (int i = 0; i < 254; i++) x = gmul(x, b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    endfunction

    function automatic void expand(input logic [255:0] key, input logic [1:0] len,
                                   output sched_t s, output int n);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nk;
        nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
        n  = nk + 7;
        s  = '0;
        for (int i = 0; i < 4 * n; i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        for (int k = 0; k < n; k++) s[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    // Runs mid-cycle: checks this cycle's outputs, then records the events the
    // coming posedge will act on, then plays the expander for the next cycle.
    task automatic model_step();
        if (c == valid_on_at) begin
            m_valid = 1'b1;
            m_num   = 4'(pend_num);
            m_sched = pend_sched;
        end
        if (m_known) begin
            chk("key_req_ready", 256'(key_req_ready), 256'(c >= free_at));
            chk("busy",          256'(busy),          256'(c >= kick_at && c <= done_at));
            chk("exp_key_flag",  256'(exp_key_flag),  256'(c == kick_at));
            chk("err_len",       256'(err_len),       256'(c == err_at));
            chk("rk_valid",      256'(rk_valid),      256'(m_valid));
            chk("rk_num",        256'(rk_num),        256'(m_num));
            chk("exp_key",       exp_key,             m_exp_key);
            chk("exp_leng_key",  256'(exp_leng_key),  256'(m_len));
            if (c == rd_at) begin
                chk("rk_rd_vld",  256'(rk_rd_vld),  256'(1'b1));
                chk("rk_rd_data", 256'(rk_rd_data), 256'(rd_exp));
                last_rd = rd_exp;
            end else begin
                chk("rk_rd_vld_idle",  256'(rk_rd_vld),  256'(1'b0));
                chk("rk_rd_data_hold", 256'(rk_rd_data), 256'(last_rd));
            end
        end
        if (rk_rd_en) begin
            rd_exp = (m_valid && rk_rd_idx < m_num) ? m_sched[rk_rd_idx] : 128'h0;
            rd_at  = c + 1;
        end
        if (!rst_n) begin
            m_known = 1; free_at = c + 1; kick_at = -10; done_at = -10; err_at = -10;
            valid_on_at = -10; rd_at = -10; m_valid = 0; m_num = 0;
            m_exp_key = 0; m_len = 0; last_rd = 0;
        end else if (m_known && key_req_valid && c >= free_at) begin
            m_exp_key = key_in;
            m_len     = key_len_in;
            if (key_len_in == 2'b11) begin
                err_at = c + 1;
            end else begin
                expand(key_in, key_len_in, pend_sched, pend_num);
                m_valid     = 1'b0;
                kick_at     = c + 1;
                done_at     = c + 2 + pend_num;
                free_at     = c + 3 + pend_num;
                valid_on_at = free_at;
            end
        end
        if (exp_key_flag) begin
            expand(exp_key, exp_leng_key, e_sched, e_n);
            e_idx = 0;
        end else if (e_idx < e_n) begin
            {exp_wo_0, exp_wo_1, exp_wo_2, exp_wo_3} = e_sched[e_idx];
            e_idx++;
        end
        c++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sched(input logic [255:0] k, input logic [1:0] l,
                             output int dt, output int flags, output int badlen);
        int a;
        key_in = k; key_len_in = l; key_req_valid = 1'b1; a = c;
        flags = 0; badlen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            key_req_valid = 1'b0;
            if (exp_key_flag) flags++;
            if (busy && exp_leng_key !== l) badlen++;
            if (rk_valid) break;
        end
        chk("rk_valid_rise", 256'(rk_valid), 256'(1'b1));
        dt = c - a;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string nm);
        rk_rd_en = 1'b1; rk_rd_idx = idx;
        tick();
        rk_rd_en = 1'b0;
        chk({nm, "_vld"}, 256'(rk_rd_vld), 256'(1'b1));
        chk(nm, 256'(rk_rd_data), 256'(exp));
    endtask

    initial begin
        int dt, flags, badlen, a1, a2;
        rst_n = 1'b0; key_req_valid = 1'b0; key_in = '0; key_len_in = '0;
        rk_rd_en = 1'b0; rk_rd_idx = '0;
        {exp_wo_0, exp_wo_1, exp_wo_2, exp_wo_3} = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_rk_valid",  256'(rk_valid),      256'(1'b0));
        chk("reset_ready",     256'(key_req_ready), 256'(1'b1));
        chk("reset_rd_data",   256'(rk_rd_data),    256'(0));

        // AES-128
        run_sched({K128, 128'hfeedface0badf00dcafebabe12345678}, 2'b00, dt, flags, badlen);
        chk("a128_latency", 256'(dt), 256'(14));
        chk("a128_rk_num",  256'(rk_num), 256'(11));
        rd(4'd0,  K128,    "a128_rk0");
        rd(4'd10, R128_10, "a128_rk10");

        // AES-256
        run_sched(K256, 2'b10, dt, flags, badlen);
        chk("a256_flags",  256'(flags),  256'(1));
        chk("a256_badlen", 256'(badlen), 256'(0));
        chk("a256_rk_num", 256'(rk_num), 256'(15));
        rd(4'd14, R256_14, "a256_rk14");

        // AES-192
        run_sched({K192, 64'h0123456789abcdef}, 2'b01, dt, flags, badlen);
        chk("a192_rk_num", 256'(rk_num), 256'(13));
        rd(4'd12, R192_12, "a192_rk12");
        rd(4'd13, 128'h0,  "a192_idx13");

        // Illegal length leaves the schedule alone
        key_in = {8{32'h5a5aa5a5}}; key_len_in = 2'b11; key_req_valid = 1'b1;
        tick();
        key_req_valid = 1'b0;
        chk("illegal_err_len", 256'(err_len), 256'(1'b1));
        chk("illegal_busy",    256'(busy),    256'(1'b0));
        tick();
        chk("illegal_rk_valid", 256'(rk_valid), 256'(1'b1));
        rd(4'd0, K192[191:64], "illegal_rk0");

        // Queued second request; read in its accept cycle sees the first schedule
        key_in = {K128, 128'h0}; key_len_in = 2'b00; key_req_valid = 1'b1; a1 = c;
        tick();
        key_in = K256; key_len_in = 2'b10;
        for (int i = 0; i < 40 && !key_req_ready; i++) tick();
        a2 = c;
        chk("queued_accept_delay", 256'(a2 - a1), 256'(14));
        rk_rd_en = 1'b1; rk_rd_idx = 4'd10;
        tick();
        key_req_valid = 1'b0; rk_rd_en = 1'b0;
        chk("queued_old_rk10", 256'(rk_rd_data), 256'(R128_10));
        for (int i = 0; i < 40 && !rk_valid; i++) tick();
        chk("queued_latency", 256'(c - a2), 256'(18));
        rd(4'd14, R256_14, "queued_rk14");

        // Reset during COLLECT
        key_in = {K128, 128'h0}; key_len_in = 2'b00; key_req_valid = 1'b1;
        tick();
        key_req_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy",     256'(busy),          256'(1'b0));
        chk("rst_rk_valid", 256'(rk_valid),      256'(1'b0));
        chk("rst_ready",    256'(key_req_ready), 256'(1'b1));
        rd(4'd0, 128'h0, "rst_read");

        // Recovery after the abandoned expansion
        run_sched({K128, 128'h0}, 2'b00, dt, flags, badlen);
        chk("recover_latency", 256'(dt), 256'(14));
        rd(4'd10, R128_10, "recover_rk10");
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
